// File: rtl/alu_control_sequencer.sv
// alu_control_sequencer: hardwired fetch/ALU control unit driving the Datapath strobes.
// Optional macro CU_ILLEGAL_TRAP_EN: illegal opcodes halt with a sticky flag instead of acting as NOPs.
module alu_control_sequencer #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 16
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] IR,
    output logic [NREGS-1:0]  Rin,
    output logic [NREGS-1:0]  Rout,
    output logic              PCout,
    output logic              PCin,
    output logic              IncPC,
    output logic              MARin,
    output logic              MDRin,
    output logic              MDRout,
    output logic              MDMuxread,
    output logic              IRin,
    output logic              Yin,
    output logic              Zlowin,
    output logic              Zhighin,
    output logic              Zlowout,
    output logic              Zhighout,
    output logic              HIin,
    output logic              LOin,
    output logic              ADD,
    output logic              SUB,
    output logic              MUL,
    output logic              DIV,
    output logic              AND,
    output logic              OR,
    output logic              SHR,
    output logic              SHRA,
    output logic              SHL,
    output logic              ROR,
    output logic              ROL,
    output logic              NEG,
    output logic              NOT,
    output logic              run,
    output logic              illegal,
    output logic [3:0]        state_dbg
);
    typedef enum logic [3:0] {
        RST = 4'd0, T0 = 4'd1, T1 = 4'd2, T2 = 4'd3, T3 = 4'd4, T4 = 4'd5,
        T5 = 4'd6, T4U = 4'd7, T5M = 4'd8, T6M = 4'd9, HALT = 4'd15
    } state_t;

`ifdef CU_ILLEGAL_TRAP_EN
    localparam state_t ILL_NEXT = HALT;
    logic illegal_q;
    assign illegal = illegal_q;
`else
    localparam state_t ILL_NEXT = T0;
    assign illegal = 1'b0;
`endif

    localparam logic [NREGS-1:0] ONE = NREGS'(1);

    state_t      state;
    logic [4:0]  op;
    logic [3:0]  ra, rb, rc;
    logic        legal, unary, muldiv, op_en;
    logic [12:0] op_v;
    logic        unused_ir;

    assign op        = IR[31:27];
    assign ra        = IR[26:23];
    assign rb        = IR[22:19];
    assign rc        = IR[18:15];
    assign unused_ir = ^IR;
    assign legal     = op <= 5'd12;
    assign unary     = op == 5'd11 || op == 5'd12;
    assign muldiv    = op == 5'd9 || op == 5'd10;

    always_ff @(posedge clock) begin
        if (clear) begin
            state <= RST;
`ifdef CU_ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
`ifdef CU_ILLEGAL_TRAP_EN
            if (state == T3 && !legal) illegal_q <= 1'b1;
`endif
            case (state)
                RST:     state <= T0;
                T0:      state <= T1;
                T1:      state <= mem_ready ? T2 : T1;
                T2:      state <= T3;
                T3:      state <= !legal ? ILL_NEXT : (unary ? T4U : T4);
                T4:      state <= muldiv ? T5M : T5;
                T5:      state <= T0;
                T4U:     state <= T0;
                T5M:     state <= T6M;
                T6M:     state <= T0;
                HALT:    state <= HALT;
                default: state <= RST;
            endcase
        end
    end

    // The ALU op line fires in T4 for two-operand ops and already in T3 for NEG/NOT.
    assign op_en = legal && ((state == T3 && unary) || state == T4);
    assign op_v  = op_en ? 13'(1) << op : 13'd0;

    always_comb begin
        Rin       = (state == T5 || state == T4U) ? ONE << ra : '0;
        Rout      = (state == T3 && legal) ? ONE << rb : (state == T4 ? ONE << rc : '0);
        PCout     = state == T0;
        MARin     = state == T0;
        IncPC     = state == T0;
        PCin      = state == T1;
        MDMuxread = state == T1;
        MDRin     = state == T1;
        MDRout    = state == T2;
        IRin      = state == T2;
        Yin       = state == T3 && legal && !unary;
        Zlowin    = state == T0 || state == T4 || (state == T3 && legal && unary);
        Zhighin   = state == T4 && muldiv;
        Zlowout   = state == T1 || state == T5 || state == T4U || state == T5M;
        LOin      = state == T5M;
        Zhighout  = state == T6M;
        HIin      = state == T6M;
        run       = state != RST && state != HALT;
    end

    assign {NOT, NEG, DIV, MUL, ROL, ROR, AND, OR, SHL, SHRA, SHR, SUB, ADD} = op_v;
    assign state_dbg = state;
endmodule

// File: tb/tb_alu_control_sequencer.sv
// tb_alu_control_sequencer: randomized bench checking the control sequence against a per-instruction cycle table.
module tb_alu_control_sequencer;
    logic        clock = 0, clear = 1, mem_ready = 0;
    logic [31:0] IR = 0;
    logic [15:0] Rin, Rout;
    logic PCout, PCin, IncPC, MARin, MDRin, MDRout, MDMuxread, IRin, Yin;
    logic Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin;
    logic ADD, SUB, MUL, DIV, AND, OR, SHR, SHRA, SHL, ROR, ROL, NEG, NOT;
    logic run, illegal;
    logic [3:0] state_dbg;
    logic [28:0] sig;

    alu_control_sequencer dut (
        .clock(clock), .clear(clear), .mem_ready(mem_ready), .IR(IR), .Rin(Rin), .Rout(Rout),
        .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout),
        .MDMuxread(MDMuxread), .IRin(IRin), .Yin(Yin), .Zlowin(Zlowin), .Zhighin(Zhighin),
        .Zlowout(Zlowout), .Zhighout(Zhighout), .HIin(HIin), .LOin(LOin), .ADD(ADD), .SUB(SUB),
        .MUL(MUL), .DIV(DIV), .AND(AND), .OR(OR), .SHR(SHR), .SHRA(SHRA), .SHL(SHL), .ROR(ROR),
        .ROL(ROL), .NEG(NEG), .NOT(NOT), .run(run), .illegal(illegal), .state_dbg(state_dbg)
    );

    always #5 clock = ~clock;

    // Bit positions of the strobe vector; ALU op lines sit at 16 + opcode.
    localparam int PCO = 0, PCI = 1, INC = 2, MAR = 3, MDI = 4, MDO = 5, MUX = 6, IRI = 7;
    localparam int YIN = 8, ZLI = 9, ZHI = 10, ZLO = 11, ZHO = 12, HII = 13, LOI = 14, RUN = 15;

    assign sig = {NOT, NEG, DIV, MUL, ROL, ROR, AND, OR, SHL, SHRA, SHR, SUB, ADD,
                  run, LOin, HIin, Zhighout, Zlowout, Zhighin, Zlowin, Yin, IRin,
                  MDMuxread, MDRout, MDRin, MARin, IncPC, PCin, PCout};

    typedef struct packed {
        logic [3:0]  st;
        logic [15:0] rin;
        logic [15:0] rout;
        logic [28:0] sig;
    } cyc_t;

    cyc_t exp_q[$];
    int checks = 0, errors = 0;
    int irin_cnt, incpc_cnt, t1_cnt;

    function automatic logic [28:0] b(input int n);
        return 29'(1) << n;
    endfunction

    task automatic push(input int st, input logic [15:0] rin, input logic [15:0] rout, input logic [28:0] s);
        exp_q.push_back('{st: 4'(st), rin: rin, rout: rout, sig: s});
    endtask

    // Expected cycle-by-cycle behaviour of one instruction, from T0 up to (not including) the next T0.
    task automatic build(input logic [31:0] ir, input int w);
        int op = int'(ir[31:27]);
        logic [15:0] ra = 16'(1) << ir[26:23], rb = 16'(1) << ir[22:19], rc = 16'(1) << ir[18:15];
        exp_q.delete();
        push(1, 0, 0, b(PCO) | b(MAR) | b(INC) | b(ZLI) | b(RUN));
        for (int k = 0; k <= w; k++) push(2, 0, 0, b(ZLO) | b(PCI) | b(MUX) | b(MDI) | b(RUN));
        push(3, 0, 0, b(MDO) | b(IRI) | b(RUN));
        if (op > 12) push(4, 0, 0, b(RUN));
        else if (op == 11 || op == 12) begin
            push(4, 0, rb, b(16 + op) | b(ZLI) | b(RUN));
            push(7, ra, 0, b(ZLO) | b(RUN));
        end else if (op == 9 || op == 10) begin
            push(4, 0, rb, b(YIN) | b(RUN));
            push(5, 0, rc, b(16 + op) | b(ZLI) | b(ZHI) | b(RUN));
            push(8, 0, 0, b(ZLO) | b(LOI) | b(RUN));
            push(9, 0, 0, b(ZHO) | b(HII) | b(RUN));
        end else begin
            push(4, 0, rb, b(YIN) | b(RUN));
            push(5, 0, rc, b(16 + op) | b(ZLI) | b(RUN));
            push(6, ra, 0, b(ZLO) | b(RUN));
        end
    endtask

    task automatic chk_idle(input string name, input logic [3:0] st);
        checks++;
        if (state_dbg !== st || sig !== 0 || Rin !== 0 || Rout !== 0 || illegal !== 0) begin
            errors++;
            $display("FAIL %s idle: state=%0d sig=%h Rin=%h Rout=%h illegal=%b, need state=%0d and all zero",
                     name, state_dbg, sig, Rin, Rout, illegal, st);
        end
    endtask

    // Runs one instruction from a T0 negedge; optionally pulls clear during table row abort_at.
    task automatic exec(input string name, input logic [31:0] ir, input int w, input int abort_at);
        int t1n = 0;
        int busn;
        build(ir, w);
        irin_cnt = 0; incpc_cnt = 0; t1_cnt = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            cyc_t e = exp_q[i];
            IR = (e.st inside {4'd1, 4'd2, 4'd3}) ? $urandom : ir;
            if (e.st == 2) begin
                mem_ready = (t1n == w);
                t1n++;
            end else mem_ready = 1'($urandom_range(0, 1));
            #1;
            irin_cnt += int'(IRin); incpc_cnt += int'(IncPC); t1_cnt += int'(MDMuxread);
            checks++;
            if (state_dbg !== e.st) begin errors++; $display("FAIL %s cyc%0d state got %0d need %0d", name, i, state_dbg, e.st); end
            checks++;
            if (sig !== e.sig) begin errors++; $display("FAIL %s cyc%0d strobes got %h need %h", name, i, sig, e.sig); end
            checks++;
            if (Rin !== e.rin || Rout !== e.rout) begin
                errors++;
                $display("FAIL %s cyc%0d Rin/Rout got %h/%h need %h/%h", name, i, Rin, Rout, e.rin, e.rout);
            end
            checks++;
            if (illegal !== 1'b0) begin errors++; $display("FAIL %s cyc%0d illegal got %b need 0", name, i, illegal); end
            busn = int'(Rout != 0) + int'(PCout) + int'(MDRout) + int'(Zlowout) + int'(Zhighout);
            checks++;
            if (!$onehot0(Rin) || !$onehot0(Rout) || busn > 1 || !$onehot0(sig[28:16])) begin
                errors++;
                $display("FAIL %s cyc%0d exclusivity Rin=%h Rout=%h bus_sources=%0d ops=%h, need one-hot-or-zero and <=1 source",
                         name, i, Rin, Rout, busn, sig[28:16]);
            end
            if (i == abort_at) begin
                clear = 1;
                @(negedge clock);
                chk_idle({name, " abort"}, 4'd0);
                clear = 0;
                @(negedge clock);
                checks++;
                if (state_dbg !== 4'd1) begin errors++; $display("FAIL %s after-abort state got %0d need 1", name, state_dbg); end
                return;
            end
            @(negedge clock);
        end
`ifdef CU_ILLEGAL_TRAP_EN
        if (ir[31:27] > 5'd12) begin
            for (int k = 0; k < 3; k++) begin
                IR = $urandom; mem_ready = 1'($urandom_range(0, 1));
                #1;
                checks++;
                if (state_dbg !== 4'd15 || run !== 0 || illegal !== 1 || sig !== 0 || Rin !== 0 || Rout !== 0) begin
                    errors++;
                    $display("FAIL %s halt%0d: state=%0d run=%b illegal=%b sig=%h, need 15/0/1/0", name, k, state_dbg, run, illegal, sig);
                end
                @(negedge clock);
            end
            clear = 1;
            @(negedge clock);
            chk_idle({name, " trap-clear"}, 4'd0);
            clear = 0;
            @(negedge clock);
        end
`endif
    endtask

    task automatic test_reset;
        clear = 1;
        repeat (2) @(negedge clock);
        chk_idle("reset", 4'd0);
        clear = 0;
        @(negedge clock);
        checks++;
        if (state_dbg !== 4'd1) begin errors++; $display("FAIL reset exit state got %0d need 1", state_dbg); end
    endtask

    task automatic test_or;
        exec("or", 32'h2891_8000, 0, -1);
        checks++;
        if (exp_q.size() !== 6) begin errors++; $display("FAIL or latency got %0d need 6", exp_q.size()); end
    endtask

    task automatic test_mem_wait;
        exec("mem_wait", 32'h0091_8000, 3, -1);
        checks++;
        if (irin_cnt !== 1 || incpc_cnt !== 1 || t1_cnt !== 4) begin
            errors++;
            $display("FAIL mem_wait counts IRin=%0d IncPC=%0d T1=%0d need 1/1/4", irin_cnt, incpc_cnt, t1_cnt);
        end
    endtask

    task automatic test_mul;
        exec("mul", 32'h4891_8000, 0, -1);
        exec("div", 32'h5111_8000, 1, -1);
    endtask

    task automatic test_not;
        exec("not", 32'h6090_0000, 0, -1);
        exec("neg", 32'h5908_0000, 2, -1);
    endtask

    task automatic test_illegal;
        exec("illegal", 32'hF800_0000, 0, -1);
        #1;
        checks++;
        if (state_dbg !== 4'd1 || illegal !== 0) begin
            errors++;
            $display("FAIL illegal next state=%0d illegal=%b need 1/0", state_dbg, illegal);
        end
    endtask

    task automatic test_reset_mid;
        exec("reset_mid", 32'h0091_8000, 0, 4);
    endtask

    task automatic test_back_to_back;
        for (int n = 0; n < 40; n++) begin
            logic [4:0] op = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 3) != 0) op = 5'($urandom_range(0, 12));
            exec("random", {op, 27'($urandom)}, $urandom_range(0, 3), -1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        @(negedge clock);
        test_reset;
        test_or;
        test_mem_wait;
        test_mul;
        test_not;
        test_illegal;
        test_reset_mid;
        test_back_to_back;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
